// File: rtl/ram_initiator.sv
// Command-to-strobe sequencer for the 64x8 RAM; one command at a time, registered outputs.
// Reads take 1 cycle plus a held response slot (stalls on rsp_ready); writes/fills commit one word per cycle.
module ram_initiator #(
  parameter int unsigned AddressSize = 6,
  parameter int unsigned WordSize    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [AddressSize-1:0] cmd_addr,
  input  logic [AddressSize-1:0] cmd_len,
  input  logic [WordSize-1:0]    cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WordSize-1:0]    rsp_data,
  output logic                   rsp_last,
  output logic                   busy,
  output logic [AddressSize-1:0] ram_address,
  output logic [WordSize-1:0]    ram_dataI,
  input  logic [WordSize-1:0]    ram_data,
  output logic                   ram_CS,
  output logic                   ram_WE,
  output logic                   ram_OE
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    RSP   = 3'd2,
    WRITE = 3'd3,
    FILL  = 3'd4
  } state_e;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpBurst = 2'b10;
  localparam logic [1:0] OpFill  = 2'b11;

  state_e                 state_q, state_d;
  logic [AddressSize-1:0] cur_addr_q, cur_addr_d;
  logic [AddressSize-1:0] count_q, count_d;
  logic [WordSize-1:0]    wdata_q, wdata_d;

  logic                   cs_q, cs_d;
  logic                   we_q, we_d;
  logic                   oe_q, oe_d;
  logic [AddressSize-1:0] ram_addr_q, ram_addr_d;
  logic [WordSize-1:0]    ram_wdat_q, ram_wdat_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WordSize-1:0]    rsp_data_q, rsp_data_d;
  logic                   rsp_last_q, rsp_last_d;
  logic                   busy_q, busy_d;
  logic                   cmd_ready_q, cmd_ready_d;

  // Sequencing: next state and working registers.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    count_d     = count_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          wdata_d    = cmd_wdata;
          count_d    = cmd_op[1] ? cmd_len : '0;
          unique case (cmd_op)
            OpRead, OpBurst: state_d = READ;
            OpWrite:         state_d = WRITE;
            OpFill:          state_d = FILL;
            default:         state_d = IDLE;
          endcase
        end
      end
      READ: begin
        rsp_data_d  = ram_data;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (count_q == '0);
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            cur_addr_d = cur_addr_q + 1'b1;
            count_d    = count_q - 1'b1;
            state_d    = READ;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      FILL: begin
        if (count_q == '0) begin
          state_d = IDLE;
        end else begin
          cur_addr_d = cur_addr_q + 1'b1;
          count_d    = count_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so every pin comes straight off a flop.
  always_comb begin
    cs_d        = !(state_d inside {READ, WRITE, FILL});
    we_d        = !(state_d inside {WRITE, FILL});
    oe_d        = (state_d != READ);
    ram_addr_d  = cs_d ? ram_addr_q : cur_addr_d;
    ram_wdat_d  = we_d ? ram_wdat_q : wdata_d;
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      count_q     <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b1;
      we_q        <= 1'b1;
      oe_q        <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdat_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdat_q  <= ram_wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_last    = rsp_last_q;
  assign ram_address = ram_addr_q;
  assign ram_dataI   = ram_wdat_q;
  assign ram_CS      = cs_q;
  assign ram_WE      = we_q;
  assign ram_OE      = oe_q;

endmodule
